// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - ID/EX output bundle between decode and execute
interface decode_stage_pipe_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] RD1E;
  logic [WIDTH-1:0] RD2E;
  logic [WIDTH-1:0] ExtImmE;
  logic [3:0]       RA1E;
  logic [3:0]       RA2E;
  logic [3:0]       WA3E;
  logic             ValidE;

  modport master (output RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E, ValidE);
  modport slave  (input  RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E, ValidE);
endinterface

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage: regfile, source select, immediate extend, ID/EX register
module decode_stage_pipe #(
  parameter int WIDTH        = 32,
  parameter int NREGS        = 16,
  parameter int PC_OFFSET_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         InstructionD,
  input  logic                ValidD,
  input  logic [WIDTH-1:0]    PCPlus8D,
  input  logic [1:0]          RegSrcD,
  input  logic [1:0]          ImmSrcD,
  input  logic                RegWriteW,
  input  logic [3:0]          WA3W,
  input  logic [WIDTH-1:0]    ResultW,
  input  logic                StallE,
  input  logic                FlushE,
  decode_stage_pipe_if.master ex
);
  localparam int         AW     = (NREGS > 2) ? $clog2(NREGS) : 1;
  localparam logic [3:0] PC_REG = 4'(NREGS - 1);

  logic [WIDTH-1:0]   rf [NREGS];
  logic               wr_en;
  logic [3:0]         ra1;
  logic [3:0]         ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic [WIDTH-1:0]   ext_imm;
  logic [WIDTH-1:0]   imm8;
  logic [63:0]        br_ext;
  logic [6:0]         rot_amt;
  logic [2*WIDTH-1:0] rot_dbl;
  logic               unused_bits;

  assign wr_en = RegWriteW && ({1'b0, WA3W} < 5'(NREGS)) && (WA3W != PC_REG);
  assign ra1   = RegSrcD[0] ? PC_REG : InstructionD[19:16];
  assign ra2   = RegSrcD[1] ? InstructionD[15:12] : InstructionD[3:0];

  // Write-through so an operand captured this edge never misses a same-cycle writeback.
  function automatic logic [WIDTH-1:0] rf_read(input logic [3:0] a);
    if ({1'b0, a} >= 5'(NREGS))
      return '0;
    if (a == PC_REG && PC_OFFSET_EN != 0)
      return PCPlus8D;
    if (wr_en && WA3W == a)
      return ResultW;
    return rf[a[AW-1:0]];
  endfunction

  always_comb begin
    rd1 = rf_read(ra1);
    rd2 = rf_read(ra2);
  end

  assign imm8    = WIDTH'(InstructionD[7:0]);
  assign br_ext  = {{40{InstructionD[23]}}, InstructionD[23:0]} << 2;
  assign rot_amt = {2'b00, InstructionD[11:8], 1'b0} % 7'(WIDTH);
  // Rotating a doubled copy leaves the rotated value in the low half.
  assign rot_dbl = {imm8, imm8} >> rot_amt;

  always_comb begin
    ext_imm = '0;
    case (ImmSrcD)
      2'b00:   ext_imm = imm8;
      2'b01:   ext_imm = WIDTH'(InstructionD[11:0]);
      2'b10:   ext_imm = br_ext[WIDTH-1:0];
      default: ext_imm = rot_dbl[WIDTH-1:0];
    endcase
  end

  assign unused_bits = ^{InstructionD[31:24], br_ext, rot_dbl};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (wr_en) begin
      rf[WA3W[AW-1:0]] <= ResultW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ex.RD1E    <= '0;
      ex.RD2E    <= '0;
      ex.ExtImmE <= '0;
      ex.RA1E    <= '0;
      ex.RA2E    <= '0;
      ex.WA3E    <= '0;
      ex.ValidE  <= 1'b0;
    end else if (!StallE) begin
      ex.RD1E    <= rd1;
      ex.RD2E    <= rd2;
      ex.ExtImmE <= ext_imm;
      ex.RA1E    <= ra1;
      ex.RA2E    <= ra2;
      ex.WA3E    <= InstructionD[15:12];
      ex.ValidE  <= ValidD;
    end
  end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        valid_d;
  logic [31:0] pc8;
  logic [1:0]  reg_src;
  logic [1:0]  imm_src;
  logic        reg_write;
  logic [3:0]  wa3w;
  logic [31:0] result;
  logic        stall;
  logic        flush;

  logic [31:0] instr16;
  logic [1:0]  reg_src16;
  logic [1:0]  imm_src16;

  decode_stage_pipe_if #(.WIDTH(32)) ex32 ();
  decode_stage_pipe_if #(.WIDTH(16)) ex16 ();

  decode_stage_pipe #(.WIDTH(32), .NREGS(16), .PC_OFFSET_EN(1)) u_dut32 (
    .clk(clk), .reset(reset), .InstructionD(instr), .ValidD(valid_d),
    .PCPlus8D(pc8), .RegSrcD(reg_src), .ImmSrcD(imm_src),
    .RegWriteW(reg_write), .WA3W(wa3w), .ResultW(result),
    .StallE(stall), .FlushE(flush), .ex(ex32)
  );

  decode_stage_pipe #(.WIDTH(16), .NREGS(8), .PC_OFFSET_EN(1)) u_dut16 (
    .clk(clk), .reset(reset), .InstructionD(instr16), .ValidD(1'b1),
    .PCPlus8D(16'h0108), .RegSrcD(reg_src16), .ImmSrcD(imm_src16),
    .RegWriteW(1'b0), .WA3W(4'd0), .ResultW(16'h0000),
    .StallE(1'b0), .FlushE(1'b0), .ex(ex16)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_state;
  logic [31:0] m_rf [16];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return pc8;
    if (reg_write && wa3w == a) return result;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_imm(input logic [1:0] mode, input logic [31:0] i);
    logic [31:0] x;
    int          r;
    case (mode)
      2'b00:   return {24'h0, i[7:0]};
      2'b01:   return {20'h0, i[11:0]};
      2'b10:   return {{6{i[23]}}, i[23:0], 2'b00};
      default: begin
        x = {24'h0, i[7:0]};
        r = 2 * int'(i[11:8]);
        return (x >> r) | (x << (32 - r));
      end
    endcase
  endfunction

  task automatic cycle(input logic rst, input logic [31:0] ins, input logic vld,
                       input logic [1:0] rs, input logic [1:0] is,
                       input logic we, input logic [3:0] wa, input logic [31:0] res,
                       input logic stl, input logic fl);
    exp_t        nxt;
    exp_t        got;
    logic [3:0]  a1;
    logic [3:0]  a2;
    reset = rst; instr = ins; valid_d = vld; reg_src = rs; imm_src = is;
    reg_write = we; wa3w = wa; result = res; stall = stl; flush = fl;
    a1 = rs[0] ? 4'd15 : ins[19:16];
    a2 = rs[1] ? ins[15:12] : ins[3:0];
    nxt = {m_read(a1), m_read(a2), m_imm(is, ins), a1, a2, ins[15:12], vld};
    if (rst || fl) e_state = '0;
    else if (!stl) e_state = nxt;
    if (rst) for (int k = 0; k < 16; k++) m_rf[k] = '0;
    else if (we && wa != 4'd15) m_rf[wa] = res;
    sb.push_back(e_state);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("rd1",   ex32.RD1E,    got.rd1);
    check("rd2",   ex32.RD2E,    got.rd2);
    check("imm",   ex32.ExtImmE, got.imm);
    check("ra1",   ex32.RA1E,    got.ra1);
    check("ra2",   ex32.RA2E,    got.ra2);
    check("wa3",   ex32.WA3E,    got.wa3);
    check("valid", ex32.ValidE,  got.valid);
  endtask

  initial begin
    pc8 = 32'h108;
    instr16 = '0; reg_src16 = 2'b00; imm_src16 = 2'b00;
    e_state = '0;
    for (int k = 0; k < 16; k++) m_rf[k] = '0;

    // reset with arbitrary inputs, then read r3
    cycle(1, 32'hA5A5_1234, 1, 2'b10, 2'b11, 1, 4'd3, 32'h55, 0, 0);
    check("rst_valid", ex32.ValidE, 0);
    check("rst_rd1", ex32.RD1E, 0);
    cycle(0, 32'h0003_0000, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("r3_after_rst", ex32.RD1E, 0);

    // write then read
    cycle(0, 32'h0, 1, 2'b00, 2'b00, 1, 4'd2, 32'hDEADBEEF, 0, 0);
    cycle(0, 32'h0002_0000, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("wr_rd_r2", ex32.RD1E, 32'hDEADBEEF);

    // write-through and PC alias
    cycle(0, 32'h0000_0005, 1, 2'b00, 2'b00, 1, 4'd5, 32'h1234, 0, 0);
    check("wthru_rd2", ex32.RD2E, 32'h1234);
    cycle(0, 32'h0, 1, 2'b00, 2'b00, 1, 4'd15, 32'hBAD0BAD0, 0, 0);
    cycle(0, 32'h0, 1, 2'b01, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("pc_alias", ex32.RD1E, 32'h108);

    // immediates
    cycle(0, 32'h00FF_FFFE, 1, 2'b00, 2'b10, 0, 4'd0, 32'h0, 0, 0);
    check("imm_br", ex32.ExtImmE, 32'hFFFFFFF8);
    cycle(0, 32'h0000_02FF, 1, 2'b00, 2'b11, 0, 4'd0, 32'h0, 0, 0);
    check("imm_rot", ex32.ExtImmE, 32'hF000000F);
    cycle(0, 32'h0000_0ABC, 1, 2'b00, 2'b01, 0, 4'd0, 32'h0, 0, 0);
    check("imm_12", ex32.ExtImmE, 32'h00000ABC);

    // stall holds A even with a writeback in flight, then flush beats stall
    cycle(0, 32'h0002_7005, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    cycle(0, 32'h0009_8001, 0, 2'b00, 2'b01, 1, 4'd2, 32'h7777, 1, 0);
    cycle(0, 32'h000A_9003, 0, 2'b10, 2'b10, 1, 4'd1, 32'h8888, 1, 0);
    check("stall_rd1", ex32.RD1E, 32'hDEADBEEF);
    check("stall_rd2", ex32.RD2E, 32'h1234);
    check("stall_wa3", ex32.WA3E, 4'd7);
    check("stall_valid", ex32.ValidE, 1);
    cycle(0, 32'h0002_7005, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 1, 1);
    check("flush_valid", ex32.ValidE, 0);
    check("flush_rd1", ex32.RD1E, 0);

    // stalled writeback reached the regfile; ValidD=0 still loads operands
    cycle(0, 32'h0002_0000, 0, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("novalid_rd1", ex32.RD1E, 32'h7777);
    check("novalid_valid", ex32.ValidE, 0);

    // reset mid-stall, then normal load
    cycle(0, 32'h0002_0000, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 1, 0);
    cycle(1, 32'h0002_0000, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 1, 0);
    cycle(0, 32'h0002_0000, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("post_rst_rd1", ex32.RD1E, 0);
    check("post_rst_valid", ex32.ValidE, 1);

    for (int n = 0; n < 60; n++)
      cycle(($urandom_range(0, 40) == 0), $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    // 16-bit / 8-register instance
    instr16 = 32'h0009_01FF; reg_src16 = 2'b00; imm_src16 = 2'b11;
    cycle(0, 32'h0, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("p16_ra1", ex16.RA1E, 4'd9);
    check("p16_rd1", ex16.RD1E, 16'h0000);
    check("p16_imm", ex16.ExtImmE, 16'hC03F);
    reg_src16 = 2'b01;
    cycle(0, 32'h0, 1, 2'b00, 2'b00, 0, 4'd0, 32'h0, 0, 0);
    check("p16_pc", ex16.RD1E, 16'h0108);
    check("p16_pc_ra1", ex16.RA1E, 4'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised decode stage for the pipelined ARM-style core. It contains:
- a write-through register file with reset,
- source-register selection,
- a four-mode immediate extender,
- an ID/EX pipeline register with stall and flush.

It sits between the fetch/decode register and the execute stage, and it consumes writeback results from the WB stage.

Parameters:
- WIDTH, 32, datapath width in bits (16..64).
- NREGS, 16, architectural register count (2..16); register NREGS-1 is the PC alias.
- PC_OFFSET_EN, 1, 1 = reads of register NREGS-1 return PCPlus8D; 0 = read the stored value.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- InstructionD  input  32  instruction in decode
- ValidD  input  1  InstructionD holds a real instruction
- PCPlus8D  input  WIDTH  PC+8 of the decode instruction
- RegSrcD  input  2  bit0: RA1 = PC reg; bit1: RA2 = Instr[15:12]
- ImmSrcD  input  2  immediate mode
- RegWriteW  input  1  writeback enable
- WA3W  input  4  writeback address
- ResultW  input  WIDTH  writeback data
- StallE  input  1  hold ID/EX contents
- FlushE  input  1  insert bubble into ID/EX
- RD1E  output  WIDTH  registered operand 1
- RD2E  output  WIDTH  registered operand 2
- ExtImmE  output  WIDTH  registered extended immediate
- RA1E  output  4  registered source address 1 (for forwarding)
- RA2E  output  4  registered source address 2
- WA3E  output  4  registered destination, Instr[15:12]
- ValidE  output  1  ID/EX holds a real instruction

Behaviour:
- The one clock is clk. Reset is synchronous and active-high on reset.

Source selection (combinational):
- RA1 = RegSrcD[0] ? NREGS-1 : Instr[19:16].
- RA2 = RegSrcD[1] ? Instr[15:12] : Instr[3:0].

Register file:
- NREGS x WIDTH storage.
- Writes on the rising clk edge when RegWriteW=1, WA3W<NREGS, and WA3W != NREGS-1. Writes to the PC alias are ignored.
- Reads are combinational.
- Write-through: if RegWriteW=1 and WA3W equals a read address (not the PC alias), that read returns ResultW in the same cycle.
- Read of address NREGS-1 returns PCPlus8D when PC_OFFSET_EN=1.
- Read of any address >= NREGS returns 0.
- Reset clears all entries to 0.

Immediate extend (combinational, result WIDTH bits):
- 00: zero-extend Instr[7:0].
- 01: zero-extend Instr[11:0].
- 10: sign-extend Instr[23:0], then shift left 2. Truncate to WIDTH if WIDTH<26.
- 11: zero-extend Instr[7:0] to WIDTH, then rotate right within WIDTH by 2*Instr[11:8] mod WIDTH.

ID/EX register (latency 1 cycle from decode inputs to *E outputs). Priority per edge is reset > FlushE > StallE > load:
- reset: all *E outputs = 0, ValidE = 0, register file cleared.
- FlushE=1: ValidE=0, RD1E/RD2E/ExtImmE/RA1E/RA2E/WA3E = 0. This overrides a simultaneous StallE.
- StallE=1 (no flush): all *E outputs hold.
- Otherwise: outputs load the current decode values, and ValidE = ValidD.

Boundary conditions:
- A writeback in the same cycle that the ID/EX register loads captures ResultW via write-through. No stale value enters EX.
- A writeback during StallE still updates the register file. ID/EX keeps its held (older) operands; the forwarding unit downstream is responsible for those.
- Reset asserted mid-stall clears everything on that edge. The first post-reset edge with reset=0 loads normally.
- ValidD=0 still loads operands, but ValidE=0.

Test Plan:
- Reset: assert reset 1 cycle with arbitrary inputs -> all *E = 0, ValidE = 0. Every register then reads 0: Instr RA1=3 -> RD1E = 0.
- Write then read: cycle 1 RegWriteW=1, WA3W=2, ResultW=0xDEADBEEF. Cycle 2 Instr[19:16]=2 -> after edge RD1E = 0xDEADBEEF.
- Write-through: same cycle RegWriteW=1, WA3W=5, ResultW=0x1234, Instr[3:0]=5, RegSrcD=00 -> next edge RD2E = 0x1234. A PC-alias write (WA3W=15) is ignored; a later read of r15 returns PCPlus8D = 0x108.
- Immediates, WIDTH=32:
  - ImmSrc=10, Instr[23:0]=0xFFFFFE -> ExtImmE = 0xFFFFFFF8.
  - ImmSrc=11, Instr[11:0]=0x2FF -> ExtImmE = 0xF000000F.
  - ImmSrc=01, Instr[11:0]=0xABC -> ExtImmE = 0x00000ABC.
- Stall/flush: load A (ValidD=1), then StallE=1 for 2 cycles with new inputs -> outputs stay A. Then FlushE=1 and StallE=1 together -> ValidE = 0, all data = 0.
- Parametric: WIDTH=16, NREGS=8; read address 9 -> RD1E = 0; ImmSrc=11, Instr=0x1FF -> ExtImmE = 0xC03F.
